// File: rtl/cpu_pkg.sv
// ============================================================================
//  Module   : cpu_pkg
//  Brief    : Shared integer-pipeline constants for the writeback stage.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/10ps
`default_nettype none

package cpu_pkg;
  localparam int          XLEN       = 32;
  localparam int          REG_ADDR_W = 5;
  localparam int          NUM_REGS   = 32;
  localparam logic [4:0]  ZERO_REG   = 5'd0;
endpackage

`default_nettype wire

// File: rtl/regfile_array.sv
// ============================================================================
//  Module   : regfile_array
//  Brief    : 32 x XLEN register storage, one write port, two raw read ports.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/10ps
`default_nettype none

module regfile_array
  import cpu_pkg::*;
#(
  parameter int XLEN = cpu_pkg::XLEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [XLEN-1:0]       wdata,
  input  logic [REG_ADDR_W-1:0] raddr1,
  input  logic [REG_ADDR_W-1:0] raddr2,
  output logic [XLEN-1:0]       rdata1,
  output logic [XLEN-1:0]       rdata2
);

  logic [XLEN-1:0] w_regs [NUM_REGS];

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_entry
    if (i == 0) begin : g_zero
      // x0 has no storage; it is hardwired to zero
      assign w_regs[i] = '0;
    end else begin : g_reg
      logic [XLEN-1:0] r_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_q <= '0;
        end else if (we && (waddr == REG_ADDR_W'(i))) begin
          r_q <= wdata;
        end
      end
      assign w_regs[i] = r_q;
    end
  end

  assign rdata1 = w_regs[raddr1];
  assign rdata2 = w_regs[raddr2];

endmodule

`default_nettype wire

// File: rtl/writeback_regfile.sv
// ============================================================================
//  Module   : writeback_regfile
//  Brief    : MEM/WB consumer: writeback mux, register file with bypassed
//             reads, forwarding export and retired-writeback counter.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/10ps
`default_nettype none

module writeback_regfile
  import cpu_pkg::*;
#(
  parameter int XLEN      = cpu_pkg::XLEN,
  parameter int BYPASS_EN = 1,
  parameter int CNT_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [XLEN-1:0]       alu_result_in,
  input  logic [XLEN-1:0]       mem_data_in,
  input  logic [REG_ADDR_W-1:0] rd_in,
  input  logic                  reg_write_in,
  input  logic                  mem_to_reg_in,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic [XLEN-1:0]       rs1_data,
  output logic [XLEN-1:0]       rs2_data,
  output logic [XLEN-1:0]       wb_data,
  output logic                  wb_valid,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [CNT_W-1:0]      retire_count
);

  localparam logic c_bypass = (BYPASS_EN != 0);

  logic [XLEN-1:0]  w_raw1;
  logic [XLEN-1:0]  w_raw2;
  logic             w_hit1;
  logic             w_hit2;
  logic [CNT_W-1:0] r_retire_count;

  assign wb_data  = mem_to_reg_in ? mem_data_in : alu_result_in;
  assign wb_valid = reg_write_in && (rd_in != ZERO_REG);
  assign wb_rd    = rd_in;

  regfile_array #(
    .XLEN (XLEN)
  ) u_array (
    .clk    (clk),
    .rst    (rst),
    .we     (wb_valid),
    .waddr  (rd_in),
    .wdata  (wb_data),
    .raddr1 (rs1_addr),
    .raddr2 (rs2_addr),
    .rdata1 (w_raw1),
    .rdata2 (w_raw2)
  );

  // Same-cycle bypass lets decode see a result before it lands in the array
  assign w_hit1 = c_bypass && wb_valid && (rs1_addr == rd_in);
  assign w_hit2 = c_bypass && wb_valid && (rs2_addr == rd_in);

  assign rs1_data = (rs1_addr == ZERO_REG) ? '0 : (w_hit1 ? wb_data : w_raw1);
  assign rs2_data = (rs2_addr == ZERO_REG) ? '0 : (w_hit2 ? wb_data : w_raw2);

  // Counts writeback slots, so x0 writes retire too
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_retire_count <= '0;
    end else if (reg_write_in) begin
      r_retire_count <= r_retire_count + CNT_W'(1);
    end
  end

  assign retire_count = r_retire_count;

endmodule

`default_nettype wire

// File: tb/tb_writeback_regfile.sv
// ============================================================================
//  Module   : tb_writeback_regfile
//  Brief    : Self-checking bench for writeback_regfile (bypass on and off).
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/10ps
`default_nettype none

module tb_writeback_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_result_in;
  logic [31:0] mem_data_in;
  logic [4:0]  rd_in;
  logic        reg_write_in;
  logic        mem_to_reg_in;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;

  logic [31:0] b_rs1, b_rs2, b_wbd, n_rs1, n_rs2, n_wbd;
  logic        b_wbv, n_wbv;
  logic [4:0]  b_wbr, n_wbr;
  logic [3:0]  b_cnt, n_cnt;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  logic [31:0] mdl [32];
  logic [3:0]  mdl_cnt;

  always #5 clk = ~clk;

  writeback_regfile #(.XLEN(32), .BYPASS_EN(1), .CNT_W(4)) dut_byp (
    .clk(clk), .rst(rst), .alu_result_in(alu_result_in), .mem_data_in(mem_data_in),
    .rd_in(rd_in), .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(b_rs1), .rs2_data(b_rs2),
    .wb_data(b_wbd), .wb_valid(b_wbv), .wb_rd(b_wbr), .retire_count(b_cnt));

  writeback_regfile #(.XLEN(32), .BYPASS_EN(0), .CNT_W(4)) dut_nob (
    .clk(clk), .rst(rst), .alu_result_in(alu_result_in), .mem_data_in(mem_data_in),
    .rd_in(rd_in), .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(n_rs1), .rs2_data(n_rs2),
    .wb_data(n_wbd), .wb_valid(n_wbv), .wb_rd(n_wbr), .retire_count(n_cnt));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_wb();
    return mem_to_reg_in ? mem_data_in : alu_result_in;
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'h0;
    if (byp && reg_write_in === 1'b1 && rd_in != 5'd0 && a == rd_in) return exp_wb();
    return mdl[a];
  endfunction

  // Architectural model: registers and counter as the ISA-level state
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mdl[i] <= 32'h0;
      mdl_cnt <= 4'd0;
    end else if (reg_write_in === 1'b1) begin
      mdl_cnt <= mdl_cnt + 4'd1;
      if (rd_in != 5'd0) mdl[rd_in] <= exp_wb();
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("byp_rs1", b_rs1, exp_read(rs1_addr, 1'b1));
      check("byp_rs2", b_rs2, exp_read(rs2_addr, 1'b1));
      check("nob_rs1", n_rs1, exp_read(rs1_addr, 1'b0));
      check("nob_rs2", n_rs2, exp_read(rs2_addr, 1'b0));
      check("byp_wb_valid", {31'h0, b_wbv}, {31'h0, reg_write_in === 1'b1 && rd_in != 5'd0});
      check("nob_wb_valid", {31'h0, n_wbv}, {31'h0, reg_write_in === 1'b1 && rd_in != 5'd0});
      check("byp_count", {28'h0, b_cnt}, {28'h0, mdl_cnt});
      check("nob_count", {28'h0, n_cnt}, {28'h0, mdl_cnt});
      if (!$isunknown({alu_result_in, mem_data_in, mem_to_reg_in, rd_in})) begin
        check("byp_wb_data", b_wbd, exp_wb());
        check("nob_wb_data", n_wbd, exp_wb());
        check("byp_wb_rd", {27'h0, b_wbr}, {27'h0, rd_in});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b0; alu_result_in = '0; mem_data_in = '0; rd_in = '0;
    reg_write_in = 1'b0; mem_to_reg_in = 1'b0; rs1_addr = '0; rs2_addr = '0;

    // Asynchronous reset between clock edges
    #11 rst = 1'b1;
    for (int i = 1; i < 32; i++) begin
      rs1_addr = 5'(i); rs2_addr = 5'(i);
      #0.1;
      check("rst_byp_rs1", b_rs1, 32'h0);
      check("rst_nob_rs2", n_rs2, 32'h0);
    end
    check("rst_byp_count", {28'h0, b_cnt}, 32'h0);
    check("rst_nob_count", {28'h0, n_cnt}, 32'h0);
    #2 rst = 1'b0;
    chk_en = 1'b1;
    step();

    // ALU writeback
    rd_in = 5'd5; reg_write_in = 1'b1; mem_to_reg_in = 1'b0;
    alu_result_in = 32'h0000_1234; mem_data_in = 32'hDEAD_BEEF; rs1_addr = 5'd1; rs2_addr = 5'd2;
    #1 check("alu_wb_data", b_wbd, 32'h0000_1234);
    check("alu_wb_valid", {31'h0, b_wbv}, 32'h1);
    step();
    reg_write_in = 1'b0; rs1_addr = 5'd5;
    #1 check("alu_x5", b_rs1, 32'h0000_1234);
    check("alu_count", {28'h0, b_cnt}, 32'h1);

    // Load writeback with same-cycle bypass
    rd_in = 5'd7; reg_write_in = 1'b1; mem_to_reg_in = 1'b1;
    mem_data_in = 32'hCAFE_F00D; rs1_addr = 5'd7; rs2_addr = 5'd7;
    #1 check("byp_hit_rs1", b_rs1, 32'hCAFE_F00D);
    check("byp_hit_rs2", b_rs2, 32'hCAFE_F00D);
    check("nob_old_rs1", n_rs1, 32'h0);
    check("nob_old_rs2", n_rs2, 32'h0);
    step();
    reg_write_in = 1'b0;
    #1 check("nob_after_rs1", n_rs1, 32'hCAFE_F00D);
    check("ld_count", {28'h0, n_cnt}, 32'h2);

    // x0 protection
    rd_in = 5'd0; reg_write_in = 1'b1; mem_to_reg_in = 1'b0;
    alu_result_in = 32'hFFFF_FFFF; rs1_addr = 5'd0;
    #1 check("x0_rs1", b_rs1, 32'h0);
    check("x0_wb_valid", {31'h0, b_wbv}, 32'h0);
    check("x0_wb_data", b_wbd, 32'hFFFF_FFFF);
    step();
    reg_write_in = 1'b0;
    #1 check("x0_rs1_after", b_rs1, 32'h0);
    check("x0_count", {28'h0, b_cnt}, 32'h3);

    // Bubbles with unknown payload
    rd_in = 'x; alu_result_in = 'x; mem_data_in = 'x; mem_to_reg_in = 1'bx;
    rs1_addr = 5'd5; rs2_addr = 5'd7;
    repeat (3) step();
    #1 check("bub_x5", b_rs1, 32'h0000_1234);
    check("bub_x7", n_rs2, 32'hCAFE_F00D);
    check("bub_count", {28'h0, b_cnt}, 32'h3);
    rd_in = '0; alu_result_in = '0; mem_data_in = '0; mem_to_reg_in = 1'b0;

    // Counter wrap: 3 + 13 writes = 16
    for (int i = 0; i < 13; i++) begin
      rd_in = 5'(i + 1); reg_write_in = 1'b1;
      alu_result_in = 32'(i) * 32'h0101_0101 + 32'h1;
      step();
    end
    reg_write_in = 1'b0; rs1_addr = 5'd13; rs2_addr = 5'd5;
    #1 check("wrap_count", {28'h0, b_cnt}, 32'h0);
    check("wrap_x13", b_rs1, 32'h0C0C_0C0D);
    check("wrap_x5", n_rs2, 32'h0404_0405);

    // Reset racing a write to x9
    step();
    rd_in = 5'd9; reg_write_in = 1'b1; alu_result_in = 32'h0000_0099; rst = 1'b1;
    step();
    rst = 1'b0; reg_write_in = 1'b0; rs1_addr = 5'd9; rs2_addr = 5'd13;
    #1 check("race_x9", n_rs1, 32'h0);
    check("race_x13", b_rs2, 32'h0);
    check("race_count", {28'h0, b_cnt}, 32'h0);
    rd_in = 5'd9; reg_write_in = 1'b1; alu_result_in = 32'h0000_0055;
    step();
    reg_write_in = 1'b0;
    #1 check("post_rst_x9", n_rs1, 32'h0000_0055);
    check("post_rst_count", {28'h0, n_cnt}, 32'h1);

    repeat (3) step();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
